// File: rtl/sar_code_collector.sv
// Collects bit-serial SAR comparator decisions into 8-bit codes, LSB first, with an
// undecided-bit flag per word, and queues them in a small FIFO with sticky overflow.
module sar_code_collector #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     op,
  input  logic                     om,
  output logic [7:0]               out_data,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [2:0]    cnt_q, cnt_d;
  logic [6:0]    part_q, part_d;
  logic          err_q, err_d;
  logic          push;
  logic          undecided;
  logic [8:0]    push_word;

  logic [8:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, pop, wr_en, ovf_set;

  assign undecided = (op == om);
  assign push_word = {err_q | undecided, op, part_q};

  // Bit collector: any cycle with en low discards the in-flight conversion.
  always_comb begin
    cnt_d  = '0;
    part_d = '0;
    err_d  = 1'b0;
    push   = 1'b0;
    if (en) begin
      if (cnt_q == 3'd7) begin
        push = 1'b1;
      end else begin
        cnt_d          = cnt_q + 3'd1;
        part_d         = part_q;
        part_d[cnt_q]  = op;
        err_d          = err_q | undecided;
      end
    end
  end

  assign full    = (level_q == LW'(DEPTH));
  assign pop     = out_valid & out_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    level_d = level_q;
    if (wr_en) wr_d = wr_q + AW'(1);
    if (pop)   rd_d = rd_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d = ovf_q;
    if (ovf_set)      ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      part_q  <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid           = (level_q != '0);
  assign {out_err, out_data} = out_valid ? mem_q[rd_q] : 9'd0;
  assign level               = level_q;
  assign ovf                 = ovf_q;

endmodule

// File: tb/tb_sar_code_collector.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor checks head/level/ovf.
module tb_sar_code_collector;

  localparam int unsigned DEPTH = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   en, op, om;
  logic [7:0]             out_data;
  logic                   out_err, out_valid, out_ready;
  logic [$clog2(DEPTH):0] level;
  logic                   ovf, clr_ovf;

  sar_code_collector #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .op        (op),
    .om        (om),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  bit         exp_ovf = 1'b0;
  int         bi      = 0;
  logic [7:0] wbits   = '0;
  bit         werr    = 1'b0;

  function automatic void chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endfunction

  // Monitor: head word must match the oldest expected code; pop when consumer accepts.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("level", int'(level), exp_q.size());
      chk("ovf", int'(ovf), int'(exp_ovf));
      chk("valid", int'(out_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("head", int'({out_err, out_data}), int'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("idle_zero", int'({out_err, out_data}), 0);
      end
    end
  end

  // One clock of stimulus; the model tracks conversions as plain bit positions.
  task automatic cycle(input logic e, input logic p, input logic m, input logic rdy,
                       input logic clr);
    bit         complete;
    bit         will_pop;
    bit         is_full;
    logic [8:0] word;
    en = e; op = p; om = m; out_ready = rdy; clr_ovf = clr;
    complete = 1'b0;
    word     = '0;
    if (e) begin
      wbits[bi] = p;
      werr      = werr | (p == m);
      if (bi == 7) begin
        complete = 1'b1;
        word     = {werr, wbits};
        bi = 0; wbits = '0; werr = 1'b0;
      end else begin
        bi++;
      end
    end else begin
      bi = 0; wbits = '0; werr = 1'b0;
    end
    will_pop = rdy && (exp_q.size() > 0);
    is_full  = (exp_q.size() == DEPTH);
    @(posedge clk);
    if (complete && is_full && !will_pop) begin
      exp_ovf = 1'b1;
    end else begin
      if (complete) exp_q.push_back(word);
      if (clr) exp_ovf = 1'b0;
    end
    #1;
  endtask

  // mode 0: never ready, 1: ready only on the last bit, 2: random ready
  task automatic convert(input logic [7:0] code, input logic [7:0] emask, input int mode);
    logic p, r;
    for (int i = 0; i < 8; i++) begin
      p = code[i];
      r = (mode == 0) ? 1'b0 : (mode == 1) ? logic'(i == 7) : logic'($urandom_range(0, 1));
      cycle(1'b1, p, emask[i] ? p : ~p, r, 1'b0);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic reset_pulse();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_err", int'(out_err), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(ovf), 0);
    exp_q.delete();
    exp_ovf = 1'b0;
    bi = 0; wbits = '0; werr = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; op = 1'b0; om = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_valid", int'(out_valid), 0);
    chk("por_level", int'(level), 0);
    chk("por_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    // Clean 0xA5, then 0xA5 with bit 3 undecided.
    convert(8'hA5, 8'h00, 0);
    idle(2, 1'b0);
    idle(2, 1'b1);
    convert(8'hA5, 8'h08, 0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Five conversions into a depth-4 FIFO, drain, then clear ovf.
    for (int k = 0; k < 5; k++) convert(8'($urandom), 8'h00, 0);
    idle(2, 1'b0);
    idle(DEPTH + 1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Full FIFO with a pop on the edge the fifth word completes.
    for (int k = 0; k < 4; k++) convert(8'($urandom), 8'h00, 0);
    convert(8'h5E, 8'h00, 1);
    idle(1, 1'b0);
    idle(DEPTH + 1, 1'b1);

    // Abort after four bits, then a full conversion.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    convert(8'h3C, 8'h00, 0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Reset mid-conversion with two words queued.
    convert(8'h11, 8'h00, 0);
    convert(8'h22, 8'h40, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_pulse();
    convert(8'hC3, 8'h00, 0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Random conversions, aborts, consumer stalls and ovf clears.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < int'($urandom_range(1, 7)); i++)
          cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      end
      convert(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00,
              2);
      if ($urandom_range(0, 3) == 0)
        cycle(1'b0, 1'b0, 1'b0, 1'($urandom), 1'($urandom_range(0, 1)));
    end
    idle(DEPTH + 2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_code_collector.md
SAR_CODE_COLLECTOR -- requirements
Module: sar_code_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO depth in words; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en  input  1  conversion enable; 1 = sample comparator every cycle.
REQ-005 SHALL have port op  input  1  comparator positive decision, same signal fed to the SAR logic.
REQ-006 SHALL have port om  input  1  comparator negative decision.
REQ-007 SHALL have port out_data  output  8  head-of-FIFO conversion code.
REQ-008 SHALL have port out_err  output  1  head word contained at least one undecided bit.
REQ-009 SHALL have port out_valid  output  1  FIFO non-empty; out_data/out_err valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head word.
REQ-011 SHALL have port level  output  clog2(DEPTH)+1  current number of stored words.
REQ-012 SHALL have port ovf  output  1  sticky overflow flag.
REQ-013 SHALL have port clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-014 SHALL keep a 3-bit bit counter, cycle-aligned with the SAR logic, incrementing by 1 each clock while en=1.
REQ-015 SHALL, each en=1 edge, write op into partial-code bit [counter]; bit 0 sampled first, bit 7 last.
REQ-016 SHALL mark a bit undecided when op=om (both 0 or both 1); per-word error accumulator ORs this over all 8 bits.
REQ-017 SHALL, on the edge sampling bit 7 (counter=7), form word {partial[6:0] with bit 7 = op} plus error flag, push it to the FIFO, and wrap counter to 0, partial and error accumulator to 0.
REQ-018 SHALL assert out_valid on the cycle after the bit-7 edge when FIFO was empty (latency 1 cycle from last bit sample).
REQ-019 SHALL, when en=0, force counter to 0 and clear partial code and error accumulator on the next edge (aborted conversion discarded, no push); FIFO unaffected.
REQ-020 SHALL pop the head word on any edge with out_valid=1 and out_ready=1.
REQ-021 SHALL hold out_data and out_err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on push with FIFO full and no pop that edge, drop the new word, leave FIFO contents unchanged, and set ovf.
REQ-023 SHALL accept a push when full if a pop occurs on the same edge (level stays DEPTH, no ovf).
REQ-024 SHALL, on simultaneous push and pop when not full, keep level unchanged and preserve FIFO order.
REQ-025 SHALL clear ovf when clr_ovf=1, except a new overflow on the same edge wins (ovf stays 1).
REQ-026 SHALL drive out_data=0 and out_err=0 whenever out_valid=0.
REQ-027 SHALL report level = pushes minus pops, range 0..DEPTH, updated on the same edge as push/pop.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously set counter=0, partial=0, error accumulator=0, FIFO empty, level=0, out_valid=0, out_data=0, out_err=0, ovf=0.
REQ-029 SHALL, on reset mid-conversion or with words queued, discard all partial and stored data; first edge after release with en=1 samples bit 0.

Verification
REQ-030 SHALL verify: en=1, op/om drive code 0xA5 (op bit0..7 = 1,0,1,0,0,1,0,1, om=~op), out_ready=0 -> out_valid=1 one cycle after 8th edge, out_data=0xA5, out_err=0, level=1.
REQ-031 SHALL verify: same sequence but op=om=0 on bit 3 -> out_data=0xA5 with bit 3 = 0 (0xA5), out_err=1.
REQ-032 SHALL verify: 5 consecutive conversions, DEPTH=4, out_ready=0 -> level=4, ovf=1, popping returns first four codes in order; clr_ovf=1 -> ovf=0.
REQ-033 SHALL verify: FIFO full, out_ready=1 held on the edge a 5th word completes -> no ovf, level stays 4, head advances.
REQ-034 SHALL verify: en dropped to 0 after 4 bits, re-raised -> no word pushed, next complete word starts at bit 0 with correct code.
REQ-035 SHALL verify: rst_n pulsed low mid-conversion with 2 words queued -> all outputs 0 immediately (asynchronous), level=0, next conversion collected correctly.
